// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator entropy collector: FSM encoding and counter sizing.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        ERROR   = 2'd3
    } state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test on the raw folded bit stream; trip is combinational
// so the collector can react in the same cycle the limit is reached.
module trng_rct
    import trng_pkg::*;
#(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample_en,
    input  logic bit_in,
    output logic trip
);

    localparam int RW = cnt_w(LIMIT + 1);
    localparam logic [RW-1:0] RUN_TRIP = RW'(LIMIT);

    logic [RW-1:0] run_q, run_d;
    logic          prev_q, prev_d;

    // run_q == 0 marks "no sample seen yet", so the first sample always starts a run of 1.
    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        trip   = 1'b0;
        if (clear) begin
            run_d  = '0;
            prev_d = 1'b0;
        end else if (sample_en) begin
            prev_d = bit_in;
            if (run_q != '0 && bit_in == prev_q) begin
                run_d = run_q + 1'b1;
            end else begin
                run_d = RW'(1);
            end
            trip = (run_d == RUN_TRIP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/ro_entropy_collector.sv
// Ring-oscillator TRNG consumer: warm-up, XOR fold, RCT health test, word packing, valid/ready output.
// Optional von Neumann debiasing is enabled by defining TRNG_VN_DEBIAS_EN.
module ro_entropy_collector
    import trng_pkg::*;
#(
    parameter int SIZE          = 8,
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_LIMIT     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [SIZE-1:0]   raw_bits,
    output logic              ro_en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail,
    input  logic              clr_fail
);

    localparam int WCW = cnt_w(WARMUP_CYCLES);
    localparam int BCW = cnt_w(WORD_W + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
    localparam logic [BCW-1:0] WORD_FULL = BCW'(WORD_W);
    localparam logic [BCW-1:0] WORD_LAST = BCW'(WORD_W - 1);

    state_e            state_q, state_d;
    logic              ro_en_q, ro_en_d;
    logic [WORD_W-1:0] rnd_data_q, rnd_data_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic              health_fail_q, health_fail_d;
    logic [WCW-1:0]    warm_q, warm_d;
    logic [BCW-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [WORD_W-1:0] shifted;
    logic              fold, bit_vld, bit_val, rct_trip, can_load;

    assign fold = ^raw_bits;

    trng_rct #(.LIMIT(RCT_LIMIT)) u_rct (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q != COLLECT),
        .sample_en (state_q == COLLECT),
        .bit_in    (fold),
        .trip      (rct_trip)
    );

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_q, pair_d, first_q, first_d;

    // Pair flag toggles every live COLLECT cycle; anything that leaves COLLECT resets pairing.
    always_comb begin
        pair_d  = 1'b0;
        first_d = 1'b0;
        bit_vld = 1'b0;
        bit_val = first_q;
        if (state_q == COLLECT && enable && !rct_trip) begin
            pair_d  = ~pair_q;
            first_d = first_q;
            if (!pair_q) begin
                first_d = fold;
            end else begin
                bit_vld = (fold != first_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            first_q <= first_d;
        end
    end
`else
    assign bit_vld = 1'b1;
    assign bit_val = fold;
`endif

    assign can_load = !rnd_valid_q || rnd_ready;
    assign shifted  = {bit_val, sr_q[WORD_W-1:1]};

    always_comb begin
        state_d       = state_q;
        ro_en_d       = ro_en_q;
        rnd_data_d    = rnd_data_q;
        rnd_valid_d   = rnd_valid_q;
        health_fail_d = health_fail_q;
        warm_d        = warm_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        if (rnd_valid_q && rnd_ready) begin
            rnd_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WARMUP;
                    ro_en_d = 1'b1;
                    warm_d  = '0;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_d = IDLE;
                    ro_en_d = 1'b0;
                end else if (warm_q == WARM_LAST) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            COLLECT: begin
                if (rct_trip) begin
                    state_d       = ERROR;
                    health_fail_d = 1'b1;
                    ro_en_d       = 1'b0;
                    rnd_valid_d   = 1'b0;
                    sr_d          = '0;
                    cnt_d         = '0;
                end else if (!enable) begin
                    state_d = IDLE;
                    ro_en_d = 1'b0;
                    sr_d    = '0;
                    cnt_d   = '0;
                end else if (cnt_q == WORD_FULL) begin
                    // Held full word: bits arriving while blocked are dropped.
                    if (can_load) begin
                        rnd_data_d  = sr_q;
                        rnd_valid_d = 1'b1;
                        sr_d        = bit_vld ? {bit_val, {(WORD_W-1){1'b0}}} : '0;
                        cnt_d       = bit_vld ? BCW'(1) : '0;
                    end
                end else if (bit_vld) begin
                    if (cnt_q == WORD_LAST && can_load) begin
                        rnd_data_d  = shifted;
                        rnd_valid_d = 1'b1;
                        sr_d        = '0;
                        cnt_d       = '0;
                    end else begin
                        sr_d  = shifted;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ERROR: begin
                ro_en_d = 1'b0;
                if (clr_fail) begin
                    state_d       = IDLE;
                    health_fail_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ro_en_q       <= 1'b0;
            rnd_data_q    <= '0;
            rnd_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
            warm_q        <= '0;
            cnt_q         <= '0;
            sr_q          <= '0;
        end else begin
            state_q       <= state_d;
            ro_en_q       <= ro_en_d;
            rnd_data_q    <= rnd_data_d;
            rnd_valid_q   <= rnd_valid_d;
            health_fail_q <= health_fail_d;
            warm_q        <= warm_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
        end
    end

    assign ro_en       = ro_en_q;
    assign rnd_data    = rnd_data_q;
    assign rnd_valid   = rnd_valid_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_ro_entropy_collector.sv
// Directed bench for ro_entropy_collector (SIZE=8, WORD_W=8, WARMUP_CYCLES=4, RCT_LIMIT=16).
// Exercises the debias path when TRNG_VN_DEBIAS_EN is defined, the plain path otherwise.
module tb_ro_entropy_collector;

    localparam int SIZE          = 8;
    localparam int WORD_W        = 8;
    localparam int WARMUP_CYCLES = 4;
    localparam int RCT_LIMIT     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [SIZE-1:0]   raw_bits;
    logic              ro_en;
    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              rnd_ready;
    logic              health_fail;
    logic              clr_fail;

    int n_cmp = 0;
    int n_err = 0;
    bit alt_nxt = 1'b1;

    ro_entropy_collector #(
        .SIZE          (SIZE),
        .WORD_W        (WORD_W),
        .WARMUP_CYCLES (WARMUP_CYCLES),
        .RCT_LIMIT     (RCT_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_bits    (raw_bits),
        .ro_en       (ro_en),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail),
        .clr_fail    (clr_fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Folds alternate 1,0,1,0... continuing from wherever the previous call stopped.
    task automatic alt_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            raw_bits = {7'd0, alt_nxt};
            alt_nxt  = ~alt_nxt;
            tick();
        end
    endtask

    task automatic warmup_ticks();
        raw_bits = 8'hFF;
        repeat (WARMUP_CYCLES) tick();
    endtask

    initial begin
        logic pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst       = 1'b1;
        enable    = 1'b0;
        raw_bits  = '0;
        rnd_ready = 1'b0;
        clr_fail  = 1'b0;
        #12;
        check("reset_ro_en", ro_en, 0);
        check("reset_valid", rnd_valid, 0);
        check("reset_data", rnd_data, 0);
        check("reset_hfail", health_fail, 0);
        rst = 1'b0;

`ifdef TRNG_VN_DEBIAS_EN
        // Debiased stream: pairs (1,0)->1, (0,1)->0, (1,1),(0,0) dropped.
        enable = 1'b1;
        tick();
        check("vn_ro_en", ro_en, 1);
        warmup_ticks();
        for (int i = 0; i < 32; i++) begin
            raw_bits = {7'd0, pat[i % 8]};
            tick();
            if (i == 26) check("vn_not_yet", rnd_valid, 0);
            if (i == 27) begin
                check("vn_valid", rnd_valid, 1);
                check("vn_data", rnd_data, 8'h55);
            end
        end
        check("vn_hold_valid", rnd_valid, 1);
        check("vn_hold_data", rnd_data, 8'h55);
`else
        // Alternating folds, consumer always ready.
        rnd_ready = 1'b1;
        enable    = 1'b1;
        tick();
        check("ro_en_rise", ro_en, 1);
        warmup_ticks();
        check("warm_no_valid", rnd_valid, 0);
        alt_nxt = 1'b1;
        alt_ticks(7);
        check("lat_not_yet", rnd_valid, 0);
        alt_ticks(1);
        check("w1_valid", rnd_valid, 1);
        check("w1_data", rnd_data, 8'h55);
        alt_ticks(7);
        check("w2_not_yet", rnd_valid, 0);
        alt_ticks(1);
        check("w2_valid", rnd_valid, 1);
        check("w2_data", rnd_data, 8'h55);

        // Backpressure: word held stable, next word loads on the handshake edge.
        rnd_ready = 1'b0;
        alt_ticks(1);
        check("bp_data_1", rnd_data, 8'h55);
        alt_ticks(9);
        check("bp_valid_10", rnd_valid, 1);
        alt_ticks(10);
        check("bp_valid_20", rnd_valid, 1);
        check("bp_data_20", rnd_data, 8'h55);
        rnd_ready = 1'b1;
        alt_ticks(1);
        check("bp_reload_valid", rnd_valid, 1);
        check("bp_reload_data", rnd_data, 8'h55);

        // Drop enable mid-word with a pending output word.
        rnd_ready = 1'b0;
        alt_ticks(4);
        enable = 1'b0;
        alt_ticks(1);
        check("drop_state", dut.state_q, 0);
        check("drop_ro_en", ro_en, 0);
        check("drop_pending", rnd_valid, 1);
        check("drop_data", rnd_data, 8'h55);
        rnd_ready = 1'b1;
        tick();
        check("drop_handshake", rnd_valid, 0);
        enable = 1'b1;
        tick();
        check("reen_ro_en", ro_en, 1);
        warmup_ticks();
        alt_nxt = 1'b1;
        alt_ticks(7);
        check("reen_not_yet", rnd_valid, 0);
        alt_ticks(1);
        check("reen_valid", rnd_valid, 1);
        check("reen_data", rnd_data, 8'h55);
        rnd_ready = 1'b0;
`endif

        // Asynchronous reset while a word is pending in COLLECT.
        check("pre_rst_valid", rnd_valid, 1);
        rst = 1'b1;
        #2;
        check("arst_ro_en", ro_en, 0);
        check("arst_valid", rnd_valid, 0);
        check("arst_data", rnd_data, 0);
        check("arst_hfail", health_fail, 0);
        rst    = 1'b0;
        enable = 1'b0;
        tick();

        // Constant folds trip the RCT on the 16th identical sample.
        rnd_ready = 1'b1;
        enable    = 1'b1;
        tick();
        warmup_ticks();
        raw_bits = 8'h00;
        for (int i = 1; i <= 15; i++) begin
            tick();
`ifndef TRNG_VN_DEBIAS_EN
            if (i == 8) check("rct_word0", rnd_valid, 1);
`endif
        end
        check("rct_not_yet", health_fail, 0);
        check("rct_ro_en_on", ro_en, 1);
        tick();
        check("rct_hfail", health_fail, 1);
        check("rct_state", dut.state_q, 3);
        check("rct_valid", rnd_valid, 0);
        check("rct_ro_en", ro_en, 0);
        tick();
        check("err_sticky", dut.state_q, 3);
        clr_fail = 1'b1;
        tick();
        clr_fail = 1'b0;
        enable   = 1'b0;
        check("clr_hfail", health_fail, 0);
        check("clr_state", dut.state_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
